alu1_rr_arbiter: RTL and testbench
==================================

Name: alu1_rr_arbiter

Overview:
Shares one Alu1 datapath instance between NR_REQ independent requesters using round-robin arbitration with valid/ready handshakes. Accepts one command at a time, registers the operands onto the ALU, and captures the ALU result and carry. It then returns them to the granted requester, holding them until that requester accepts. Sits between the issue-side clients and the single combinational Alu1 instance.

Parameters:
WIDTH, 64, operand/result width; must match the attached Alu1.
NR_REQ, 4, number of requesters; any value >= 2, not restricted to powers of two.
CMD_WIDTH, 4, ALU command width; equals ALU1_CMD_WIDTH.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req_valid  input  NR_REQ  per-requester command valid.
req_ready  output  NR_REQ  per-requester accept; one-hot or zero.
req_cmd  input  NR_REQ*CMD_WIDTH  packed commands; requester i uses slice [i*CMD_WIDTH +: CMD_WIDTH].
req_in1  input  NR_REQ*WIDTH  packed operand 1.
req_in2  input  NR_REQ*WIDTH  packed operand 2.
rsp_valid  output  NR_REQ  per-requester result valid; one-hot or zero.
rsp_ready  input  NR_REQ  per-requester result accept.
rsp_out  output  WIDTH  result, shared by all requesters.
rsp_co  output  1  carry-out, shared by all requesters.
alu_cmd  output  CMD_WIDTH  registered command to Alu1.
alu_in1  output  WIDTH  registered operand 1 to Alu1.
alu_in2  output  WIDTH  registered operand 2 to Alu1.
alu_out  input  WIDTH  Alu1 result.
alu_co  input  1  Alu1 carry-out.

Behaviour:
- Reset values: all outputs 0, including alu_cmd=0 (transfer), rsp_out=0, rsp_co=0. FSM is IDLE. Round-robin pointer is 0, giving requester 0 highest priority.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The winner is the first asserted req_valid, searching from the pointer upward with wrap modulo NR_REQ.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0.
  - On the handshake: latch the winner's cmd/in1/in2 into alu_*, latch the winner index into gnt, set pointer=(winner+1) mod NR_REQ, go to EXEC.
  - With no req_valid, stay in IDLE; pointer and alu_* hold.
- EXEC (exactly 1 cycle):
  - alu_* are stable.
  - At the clock edge, capture alu_out into rsp_out and alu_co into rsp_co, set rsp_valid[gnt]=1, go to RESP.
- RESP:
  - rsp_valid[gnt], rsp_out and rsp_co are held stable until rsp_ready[gnt]=1.
  - On that handshake, clear rsp_valid and go to IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
  - req_ready=0 in EXEC and RESP; no new grant until the next IDLE.
- Latency: request handshake at cycle N means rsp_valid is high from cycle N+2. Minimum issue interval is 3 cycles.
- Arithmetic: the block performs none; results are Alu1 values as captured, width WIDTH. alu_* hold their last values after completion, so there is no ALU toggle while idle.
- Simultaneous events:
  - Several req_valid asserted: the round-robin pointer decides.
  - A requester whose request was just granted and which is still asserting req_valid is not re-granted before others that are pending.
- A requester dropping req_valid before its handshake loses its turn; there is no penalty.
- Reset mid-operation (EXEC or RESP): asynchronous return to reset values. The pending response is discarded and no rsp_valid is produced.

Optional Feature:
Macro ALU1_ARB_CMD_CHECK_EN.
- With the macro: adds output rsp_err (1 bit, reset 0).
  - An accepted cmd >= ALU1_NR_COMMANDS (12..15) is flagged.
  - In EXEC, the flagged command sets rsp_out=0, rsp_co=0 and rsp_err=1, with the same timing as a normal result.
  - rsp_err is valid only together with rsp_valid.
- Without the macro: the rsp_err port is absent and the command is forwarded to Alu1 unchecked.

Test Plan:
1. Only req_valid[0] set, cmd=2 (ADD), in1=5, in2=7 -> rsp_valid[0] two cycles after the handshake, rsp_out=12, rsp_co=0.
2. All four req_valid held high, rsp_ready tied high -> grant order 0,1,2,3,0,1, with one grant every 3 cycles.
3. cmd=5 (SUB), in1=3, in2=5, WIDTH=64 -> rsp_out=0xFFFF_FFFF_FFFF_FFFE, rsp_co=0. Then in1=5, in2=3 -> rsp_out=2, rsp_co=1.
4. rsp_ready[gnt] held low for 5 cycles while other requesters are valid -> rsp_valid, rsp_out and rsp_co stay stable; all req_ready remain 0; the handshake on cycle 6 returns the FSM to IDLE.
5. rst_n pulsed low during EXEC -> all outputs 0 immediately. After release, requester 0 wins first even if it was granted last.
6. With ALU1_ARB_CMD_CHECK_EN defined, cmd=13 -> rsp_valid with rsp_err=1, rsp_out=0, rsp_co=0. The next cmd=9 (OR), in1=0xF0, in2=0x0F gives rsp_out=0xFF, rsp_err=0.

Source files
------------

// File: rtl/alu1_rr_arbiter_if.sv
// Requester-side bus of alu1_rr_arbiter: packed per-requester command/operand
// lanes plus shared result lanes. rsp_err exists only with ALU1_ARB_CMD_CHECK_EN.
interface alu1_rr_arbiter_if #(
  parameter int WIDTH     = 64,
  parameter int NR_REQ    = 4,
  parameter int CMD_WIDTH = 4
);
  logic [NR_REQ-1:0]           req_valid;
  logic [NR_REQ-1:0]           req_ready;
  logic [NR_REQ*CMD_WIDTH-1:0] req_cmd;
  logic [NR_REQ*WIDTH-1:0]     req_in1;
  logic [NR_REQ*WIDTH-1:0]     req_in2;
  logic [NR_REQ-1:0]           rsp_valid;
  logic [NR_REQ-1:0]           rsp_ready;
  logic [WIDTH-1:0]            rsp_out;
  logic                        rsp_co;
`ifdef ALU1_ARB_CMD_CHECK_EN
  logic                        rsp_err;

  modport master (
    output req_valid, req_cmd, req_in1, req_in2, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_co, rsp_err
  );
  modport slave (
    input  req_valid, req_cmd, req_in1, req_in2, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_co, rsp_err
  );
`else
  modport master (
    output req_valid, req_cmd, req_in1, req_in2, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_co
  );
  modport slave (
    input  req_valid, req_cmd, req_in1, req_in2, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_co
  );
`endif
endinterface

// File: rtl/alu1_rr_arbiter.sv
// Round-robin sharing of one combinational Alu1 among NR_REQ requesters.
// Optional ALU1_ARB_CMD_CHECK_EN flags unsupported commands on rsp_err.
module alu1_rr_arbiter #(
  parameter int WIDTH     = 64,
  parameter int NR_REQ    = 4,
  parameter int CMD_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu1_rr_arbiter_if.slave     bus,
  output logic [CMD_WIDTH-1:0] alu_cmd,
  output logic [WIDTH-1:0]     alu_in1,
  output logic [WIDTH-1:0]     alu_in2,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_co,
  output logic [1:0]           dbg_state_o
);
  localparam int PTR_W = $clog2(NR_REQ);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NR_REQ - 1);
  localparam logic [NR_REQ-1:0] ONE_HOT0 = {{(NR_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, gnt_q;
  logic [CMD_WIDTH-1:0]   alu_cmd_q;
  logic [WIDTH-1:0]       alu_in1_q, alu_in2_q, rsp_out_q;
  logic                   rsp_co_q;
  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       idx_l;
  int                     idx_v;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never waits on anything but arbiter state and req_valid.

  // Winner search starts at ptr_q and wraps modulo NR_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_v     = 0;
    idx_l     = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      idx_v = int'(ptr_q) + i;
      if (idx_v >= NR_REQ) idx_v = idx_v - NR_REQ;
      idx_l = PTR_W'(idx_v);
      if (!win_found && bus.req_valid[idx_l]) begin
        win_found = 1'b1;
        win_idx   = idx_l;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready[gnt_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (state_q == IDLE && win_found) bus.req_ready = ONE_HOT0 << win_idx;
    if (state_q == RESP)              bus.rsp_valid = ONE_HOT0 << gnt_q;
  end

`ifdef ALU1_ARB_CMD_CHECK_EN
  localparam logic [CMD_WIDTH-1:0] ALU1_NR_COMMANDS = CMD_WIDTH'(12);
  logic cmd_bad_q, rsp_err_q;
  logic [CMD_WIDTH-1:0] win_cmd;

  assign win_cmd = bus.req_cmd[win_idx*CMD_WIDTH +: CMD_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_bad_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && win_found) cmd_bad_q <= (win_cmd >= ALU1_NR_COMMANDS);
      if (state_q == EXEC)              rsp_err_q <= cmd_bad_q;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      gnt_q     <= '0;
      alu_cmd_q <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      rsp_out_q <= '0;
      rsp_co_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && win_found) begin
        alu_cmd_q <= bus.req_cmd[win_idx*CMD_WIDTH +: CMD_WIDTH];
        alu_in1_q <= bus.req_in1[win_idx*WIDTH +: WIDTH];
        alu_in2_q <= bus.req_in2[win_idx*WIDTH +: WIDTH];
        gnt_q     <= win_idx;
        ptr_q     <= (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
      end
      if (state_q == EXEC) begin
`ifdef ALU1_ARB_CMD_CHECK_EN
        // Unsupported commands return a clean zero result instead of ALU noise.
        rsp_out_q <= cmd_bad_q ? '0 : alu_out;
        rsp_co_q  <= cmd_bad_q ? 1'b0 : alu_co;
`else
        rsp_out_q <= alu_out;
        rsp_co_q  <= alu_co;
`endif
      end
    end
  end

  assign alu_cmd     = alu_cmd_q;
  assign alu_in1     = alu_in1_q;
  assign alu_in2     = alu_in2_q;
  assign bus.rsp_out = rsp_out_q;
  assign bus.rsp_co  = rsp_co_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_alu1_rr_arbiter.sv
// Directed bench for alu1_rr_arbiter with a small Alu1 stand-in model.
// Define ALU1_ARB_CMD_CHECK_EN to also exercise the command-check feature.
module tb_alu1_rr_arbiter;
  localparam int W  = 64;
  localparam int NR = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] alu_cmd;
  logic [W-1:0]  alu_in1, alu_in2, alu_out;
  logic          alu_co;
  logic [1:0]    dbg_state;

  int tests_run = 0;
  int fail_cnt  = 0;
  logic          last_err;
  logic [W-1:0]  exp_q[$];

  alu1_rr_arbiter_if #(.WIDTH(W), .NR_REQ(NR), .CMD_WIDTH(CW)) bus ();

  alu1_rr_arbiter #(.WIDTH(W), .NR_REQ(NR), .CMD_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .alu_cmd     (alu_cmd),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_out     (alu_out),
    .alu_co      (alu_co),
    .dbg_state_o (dbg_state)
  );

  // Alu1 stand-in: transfer, ADD, SUB (co = no borrow), OR; anything else = ~in1, co=1.
  always_comb begin
    alu_out = '0;
    alu_co  = 1'b0;
    case (alu_cmd)
      4'd0: alu_out = alu_in1;
      4'd2: {alu_co, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
      4'd5: begin alu_out = alu_in1 - alu_in2; alu_co = (alu_in1 >= alu_in2); end
      4'd9: alu_out = alu_in1 | alu_in2;
      default: begin alu_out = ~alu_in1; alu_co = 1'b1; end
    endcase
  end

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int idx);
    logic [NR-1:0] one;
    one = 1;
    return one << idx;
  endfunction

  // Driver: one full request/response transaction for requester idx
  task automatic do_txn(input int idx, input logic [CW-1:0] cmd, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_out,
                        input logic exp_co, input string tag);
    int n;
    bus.req_cmd[idx*CW +: CW] = cmd;
    bus.req_in1[idx*W +: W]   = a;
    bus.req_in2[idx*W +: W]   = b;
    bus.req_valid[idx]        = 1'b1;
    n = 0;
    #1;
    while (!bus.req_ready[idx] && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_grant"}, W'(bus.req_ready), W'(onehot(idx)));
    @(negedge clk);
    bus.req_valid[idx] = 1'b0;
    #1;
    check({tag, "_exec_nrsp"}, W'(bus.rsp_valid), '0);
    check({tag, "_alu_in1"}, alu_in1, a);
    @(negedge clk); #1;
    check({tag, "_rsp_valid"}, W'(bus.rsp_valid), W'(onehot(idx)));
    check({tag, "_rsp_out"}, bus.rsp_out, exp_out);
    check({tag, "_rsp_co"}, W'(bus.rsp_co), W'(exp_co));
`ifdef ALU1_ARB_CMD_CHECK_EN
    last_err = bus.rsp_err;
`else
    last_err = 1'b0;
`endif
    bus.rsp_ready[idx] = 1'b1;
    @(negedge clk);
    bus.rsp_ready[idx] = 1'b0;
    #1;
    check({tag, "_rsp_done"}, W'(bus.rsp_valid), '0);
  endtask

  initial begin
    int n_gnt, last_c, g;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_cmd   = '0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    last_err = 1'b0;
    #1;
    check("rst_state", W'(dbg_state), '0);
    check("rst_alu_cmd", W'(alu_cmd), '0);
    check("rst_alu_in1", alu_in1, '0);
    check("rst_rsp_out", bus.rsp_out, '0);
    check("rst_rsp_valid", W'(bus.rsp_valid), '0);
    check("rst_req_ready", W'(bus.req_ready), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Round robin with every requester valid and responses always accepted
    for (int i = 0; i < NR; i++) begin
      bus.req_cmd[i*CW +: CW] = 4'd2;
      bus.req_in1[i*W +: W]   = W'(16 * (i + 1));
      bus.req_in2[i*W +: W]   = W'(i);
    end
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    exp_q = '{0, 1, 2, 3, 0, 1};
    n_gnt  = 0;
    last_c = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.req_ready != '0 && n_gnt < 6) begin
        g = 0;
        for (int k = 0; k < NR; k++) if (bus.req_ready[k]) g = k;
        check("rr_order", W'(g), exp_q.pop_front());
        if (n_gnt > 0) check("rr_interval", W'(c - last_c), W'(3));
        last_c = c;
        n_gnt++;
      end
      if (bus.rsp_valid != '0) begin
        g = 0;
        for (int k = 0; k < NR; k++) if (bus.rsp_valid[k]) g = k;
        check("rr_result", bus.rsp_out, W'(17 * g + 16));
      end
      @(negedge clk);
    end
    check("rr_count", W'(n_gnt), W'(6));
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
    bus.rsp_ready = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester ADD, then SUB in both directions
    do_txn(0, 4'd2, 64'd5, 64'd7, 64'd12, 1'b0, "add");
    do_txn(1, 4'd5, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "sub_neg");
    do_txn(1, 4'd5, 64'd5, 64'd3, 64'd2, 1'b1, "sub_pos");

    // Response back-pressure on requester 2 while the others wait
    bus.req_cmd[2*CW +: CW] = 4'd2;
    bus.req_in1[2*W +: W]   = 64'd100;
    bus.req_in2[2*W +: W]   = 64'd23;
    bus.req_valid = 4'b0100;
    #1;
    check("bp_grant", W'(bus.req_ready), W'(4'b0100));
    @(negedge clk);
    bus.req_valid = 4'b1011;
    bus.rsp_ready = 4'b1011;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rsp_valid", W'(bus.rsp_valid), W'(4'b0100));
      check("bp_rsp_out", bus.rsp_out, 64'd123);
      check("bp_rsp_co", W'(bus.rsp_co), '0);
      check("bp_req_ready", W'(bus.req_ready), '0);
      @(negedge clk);
    end
    bus.rsp_ready = 4'b0100;
    @(negedge clk); #1;
    check("bp_idle", W'(dbg_state), '0);
    check("bp_rsp_clear", W'(bus.rsp_valid), '0);
    check("bp_next_grant", W'(bus.req_ready), W'(4'b1000));
    bus.req_valid = '0;
    bus.rsp_ready = '0;

    // Reset during EXEC discards the pending response and rewinds the pointer
    do_txn(3, 4'd2, 64'd40, 64'd2, 64'd42, 1'b0, "pre_rst");
    bus.req_cmd[0*CW +: CW] = 4'd2;
    bus.req_in1[0*W +: W]   = 64'd1;
    bus.req_in2[0*W +: W]   = 64'd1;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("mid_exec", W'(dbg_state), W'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", W'(dbg_state), '0);
    check("mid_rst_alu_in1", alu_in1, '0);
    check("mid_rst_alu_cmd", W'(alu_cmd), '0);
    check("mid_rst_rsp_out", bus.rsp_out, '0);
    check("mid_rst_rsp_valid", W'(bus.rsp_valid), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("post_rst_no_rsp", W'(bus.rsp_valid), '0);
    bus.req_valid = 4'b0011;
    #1;
    check("post_rst_grant0", W'(bus.req_ready), W'(4'b0001));
    bus.req_valid = '0;
    @(negedge clk);

`ifdef ALU1_ARB_CMD_CHECK_EN
    do_txn(2, 4'd13, 64'hAA, 64'h55, 64'd0, 1'b0, "bad_cmd");
    check("bad_cmd_err", W'(last_err), W'(1));
    do_txn(2, 4'd9, 64'hF0, 64'h0F, 64'hFF, 1'b0, "or_cmd");
    check("or_cmd_err", W'(last_err), '0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end
endmodule
